blur_frame_scheduler: RTL and testbench

// Sequences the Gaussian blur datapath (3x3, 5x5, 7x7 kernels) over one COLSxROWS frame.

---
 rtl/sift_pkg.sv | 21 ++
 rtl/raster_counter.sv | 42 ++++
 rtl/blur_frame_scheduler.sv | 134 +++++++++++++
 tb/tb_blur_frame_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
`default_nettype none
// sift_pkg: frame geometry, scheduler state encoding and kernel margin helper
// Rev 1.0
package sift_pkg;
  localparam int COLS  = 640;
  localparam int ROWS  = 480;
  localparam int MAX_K = 7;
  localparam int PADR  = (MAX_K - 1) / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int h(input int k);
    return (k - 1) / 2;
  endfunction
endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// raster_counter: column/row raster position with row-wrap and last-pixel flags
// Rev 1.0
module raster_counter #(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_adv,
  output logic [9:0] o_col,
  output logic [9:0] o_row,
  output logic       o_row_wrap,
  output logic       o_last_pixel
);
  logic [9:0] r_col;
  logic [9:0] r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_row_wrap) begin
        r_col <= '0;
        r_row <= r_row + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_row_wrap   = (int'(r_col) == COLS - 1);
  assign o_last_pixel = o_row_wrap && (int'(r_row) == ROWS - 1);
endmodule
`default_nettype wire

// File: rtl/blur_frame_scheduler.sv
`default_nettype none
// blur_frame_scheduler: drives the line-buffer ring for one frame, tags writes with
// window centre/validity and injects zero-pad rows to drain the bottom border. Rev 1.0
module blur_frame_scheduler #(
  parameter int COLS  = sift_pkg::COLS,
  parameter int ROWS  = sift_pkg::ROWS,
  parameter int MAX_K = sift_pkg::MAX_K
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lb_wr_en,
  output logic [2:0] lb_wr_sel,
  output logic [9:0] lb_addr,
  output logic       pad,
  output logic [8:0] cen_row,
  output logic [9:0] cen_col,
  output logic       win_valid3,
  output logic       win_valid5,
  output logic       win_valid7,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);
  localparam int PADR     = (MAX_K - 1) / 2;
  localparam int LAST_SEL = MAX_K - 2;
  localparam int LAST_ROW = ROWS + PADR - 1;
  import sift_pkg::*;

  state_t     r_state, w_next;
  logic [9:0] w_col, w_row;
  logic       w_row_wrap, w_last_pixel;
  logic       w_start, w_accept, w_pad_cyc, w_adv, w_flush_end;
  logic [2:0] r_sel;
  logic       r_wr_en, r_pad, r_busy, r_done, r_overrun, r_v3, r_v5, r_v7;
  logic [2:0] r_wr_sel;
  logic [9:0] r_addr, r_cen_col;
  logic [8:0] r_cen_row;

  // Row range shifts by PADR because writes lead the window centre by PADR rows/cols.
  function automatic logic win_ok(input logic [9:0] row, input logic [9:0] col, input int k);
    return (int'(row) >= PADR + h(k)) && (int'(row) <= ROWS - 1 - h(k) + PADR) &&
           (int'(col) >= 2 * PADR) && (int'(col) <= COLS - 1);
  endfunction

  assign w_start     = start && (r_state == IDLE);
  assign w_accept    = in_valid && (r_state == STREAM);
  assign w_pad_cyc   = (r_state == FLUSH);
  assign w_adv       = w_accept || w_pad_cyc;
  assign w_flush_end = w_pad_cyc && w_row_wrap && (int'(w_row) == LAST_ROW);

  raster_counter #(.COLS(COLS), .ROWS(ROWS)) u_raster (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_start),
    .i_adv       (w_adv),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_row_wrap  (w_row_wrap),
    .o_last_pixel(w_last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = STREAM;
      STREAM:  if (w_accept && w_last_pixel) w_next = FLUSH;
      FLUSH:   if (w_flush_end) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_wr_en   <= 1'b0;
      r_pad     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_wr_sel  <= '0;
      r_addr    <= '0;
      r_cen_row <= '0;
      r_cen_col <= '0;
      r_v3      <= 1'b0;
      r_v5      <= 1'b0;
      r_v7      <= 1'b0;
    end else begin
      r_wr_en <= w_adv;
      r_pad   <= w_pad_cyc;
      r_busy  <= (r_state != IDLE);
      r_done  <= (r_state == DONE);
      if (w_start)                      r_overrun <= 1'b0;
      else if (in_valid && !in_ready)   r_overrun <= 1'b1;
      if (w_start) begin
        r_sel <= '0;
      end else if (w_adv && w_row_wrap) begin
        r_sel <= (r_sel == 3'(LAST_SEL)) ? 3'd0 : r_sel + 3'd1;
      end
      if (w_adv) begin
        r_wr_sel  <= r_sel;
        r_addr    <= w_col;
        r_cen_row <= 9'(w_row - 10'(PADR));
        r_cen_col <= w_col - 10'(PADR);
        r_v3      <= win_ok(w_row, w_col, 3);
        r_v5      <= win_ok(w_row, w_col, 5);
        r_v7      <= win_ok(w_row, w_col, 7);
      end
    end
  end

  assign in_ready   = (r_state == STREAM);
  assign lb_wr_en   = r_wr_en;
  assign lb_wr_sel  = r_wr_sel;
  assign lb_addr    = r_addr;
  assign pad        = r_pad;
  assign cen_row    = r_cen_row;
  assign cen_col    = r_cen_col;
  assign win_valid3 = r_v3;
  assign win_valid5 = r_v5;
  assign win_valid7 = r_v7;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_blur_frame_scheduler.sv
`default_nettype none
// tb_blur_frame_scheduler: scoreboard bench on an 8x6 frame with randomized valid gaps
// Rev 1.0
module tb_blur_frame_scheduler;
  localparam int COLS  = 8;
  localparam int ROWS  = 6;
  localparam int MAX_K = 7;
  localparam int PADR  = 3;
  localparam int NPIX  = COLS * ROWS;
  localparam int NPAD  = PADR * COLS;
  localparam int NWR   = NPIX + NPAD;

  logic       clk, rst, start, in_valid;
  logic       in_ready, lb_wr_en, pad, win_valid3, win_valid5, win_valid7;
  logic       busy, frame_done, overrun;
  logic [2:0] lb_wr_sel;
  logic [9:0] lb_addr, cen_col;
  logic [8:0] cen_row;

  blur_frame_scheduler #(.COLS(COLS), .ROWS(ROWS), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .lb_wr_en(lb_wr_en), .lb_wr_sel(lb_wr_sel), .lb_addr(lb_addr), .pad(pad),
    .cen_row(cen_row), .cen_col(cen_col), .win_valid3(win_valid3),
    .win_valid5(win_valid5), .win_valid7(win_valid7), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel, addr, pad, crow, ccol, v3, v5, v7, care;
  } exp_t;

  exp_t   q[$];
  int     checks = 0, errors = 0;
  int     wr_in_frame = 0, done_count = 0;
  longint cyc = 0, last_wr_cyc = -10;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int in_win(input int cr, input int cc, input int k);
    int hh = (k - 1) / 2;
    return (cr >= hh && cr <= ROWS - 1 - hh && cc >= PADR && cc <= COLS - 1 - PADR) ? 1 : 0;
  endfunction

  // Reference: n-th write of a frame in raster order, pads following the image.
  function automatic exp_t model(input int n);
    exp_t e;
    int row = n / COLS;
    int col = n % COLS;
    e.sel  = row % (MAX_K - 1);
    e.addr = col;
    e.pad  = (n >= NPIX) ? 1 : 0;
    e.care = (row >= PADR && col >= PADR) ? 1 : 0;
    e.crow = row - PADR;
    e.ccol = col - PADR;
    e.v3   = e.care ? in_win(e.crow, e.ccol, 3) : 0;
    e.v5   = e.care ? in_win(e.crow, e.ccol, 5) : 0;
    e.v7   = e.care ? in_win(e.crow, e.ccol, 7) : 0;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (lb_wr_en === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = q.pop_front();
        check("wr_sel", lb_wr_sel, e.sel);
        check("wr_addr", lb_addr, e.addr);
        check("wr_pad", pad, e.pad);
        check("win3", win_valid3, e.v3);
        check("win5", win_valid5, e.v5);
        check("win7", win_valid7, e.v7);
        if (e.care != 0) begin
          check("cen_row", cen_row, e.crow);
          check("cen_col", cen_col, e.ccol);
        end
      end
      wr_in_frame++;
      last_wr_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      check("done_after_last_write", cyc - last_wr_cyc, 1);
      check("done_write_count", wr_in_frame, NWR);
      done_count++;
      wr_in_frame = 0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, lb_wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_fields"}, {lb_wr_sel, lb_addr, pad, cen_row, cen_col,
                             win_valid3, win_valid5, win_valid7}, 0);
  endtask

  // mode 0: back-to-back, 1: alternating, 2: random gaps plus a stray start
  task automatic run_frame(input int mode, input int abort_at, input bit flush_ov);
    int     beat = 0, guard = 0, tog = 0, w = 0, d0;
    bit     v;
    longint c0;
    d0 = done_count;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c0 = cyc;
    check("overrun_cleared_by_start", overrun, 0);
    while (beat < NPIX && guard < 2000) begin
      guard++;
      if (beat == abort_at) begin
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        q.delete();
        wr_in_frame = 0;
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_frame_done", done_count - d0, 0);
        return;
      end
      start = (mode == 2 && beat == 10) ? 1'b1 : 1'b0;
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = ((tog++ % 2) == 0);
      else                v = ($urandom_range(0, 9) < 7);
      if (in_ready && v) begin
        in_valid = 1'b1;
        q.push_back(model(beat));
        beat++;
        if (beat == NPIX)
          for (int i = 0; i < NPAD; i++) q.push_back(model(NPIX + i));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (guard >= 2000) check("stream_timeout", 1, 0);
    in_valid = flush_ov;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    if (flush_ov) check("overrun_in_flush", overrun, 1);
    while (done_count == d0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("frame_done_seen", done_count - d0, 1);
    if (mode == 1) check("alt_cycles_doubled", (cyc - c0) >= 2 * NPIX - 1, 1);
    repeat (5) @(negedge clk);
    check("frame_done_once", done_count - d0, 1);
    check("busy_low_after_done", busy, 0);
    check("scoreboard_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);

    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("overrun_idle", overrun, 1);
    repeat (3) @(negedge clk);
    check("overrun_sticky_idle", overrun, 1);

    run_frame(2, -1, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun_sticky_after_frame", overrun, 1);

    run_frame(0, 20, 1'b0);
    run_frame(0, -1, 1'b0);
    run_frame(2, -1, 1'b0);
    run_frame(2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
